// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : alu_rr_arbiter
// Brief   : Round-robin sharing of one external 4-bit ALU among NUM_REQ
//           requesters, with a valid/ready tagged response channel.
// Revision: 1.0 - initial release
// =============================================================================
module alu_rr_arbiter #(
  parameter int  NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [4*NUM_REQ-1:0]   req_a,
  input  logic [4*NUM_REQ-1:0]   req_b,
  input  logic [2*NUM_REQ-1:0]   req_sel,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [1:0]             alu_sel,
  input  logic [3:0]             alu_result,
  input  logic                   alu_carry,
  input  logic                   alu_borrow,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [3:0]             rsp_result,
  output logic                   rsp_carry,
  output logic                   rsp_borrow,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);

  localparam int CW = ID_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] pick;
  logic            found;
  logic [CW-1:0]   cand;

  // Scan from the requester after the last grant, wrapping modulo NUM_REQ.
  always_comb begin
    pick  = last_grant;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + CW'(k);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!found && req[cand[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      grant      <= '0;
      req_ack    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_borrow <= 1'b0;
      rsp_id     <= '0;
      busy       <= 1'b0;
    end else begin
      req_ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant   <= pick;
            alu_a   <= req_a[int'(pick)*4 +: 4];
            alu_b   <= req_b[int'(pick)*4 +: 4];
            alu_sel <= req_sel[int'(pick)*2 +: 2];
            req_ack <= NUM_REQ'(1) << pick;
            busy    <= 1'b1;
          end
        end
        ISSUE: begin
          // Flags are only meaningful for the op that produces them.
          rsp_result <= alu_result;
          rsp_carry  <= (alu_sel == 2'b00) && alu_carry;
          rsp_borrow <= (alu_sel == 2'b01) && alu_borrow;
          rsp_id     <= grant;
          rsp_valid  <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
            last_grant <= grant;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : tb_alu_rr_arbiter
// Brief   : Directed bench with a transaction-level reference model for
//           alu_rr_arbiter, driving an ideal external ALU.
// Revision: 1.0 - initial release
// =============================================================================
module tb_alu_rr_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b1;
  logic [N-1:0]     req       = '0;
  logic [4*N-1:0]   req_a     = '0;
  logic [4*N-1:0]   req_b     = '0;
  logic [2*N-1:0]   req_sel   = '0;
  logic             rsp_ready = 1'b1;
  logic [N-1:0]     req_ack;
  logic [3:0]       alu_a, alu_b, alu_result, rsp_result;
  logic [1:0]       alu_sel;
  logic             alu_carry, alu_borrow, rsp_valid, rsp_carry, rsp_borrow, busy;
  logic [IDW-1:0]   rsp_id;
  logic [4:0]       alu_sum, alu_diff;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0] ack_q[$];
  int           id_q[$];

  alu_rr_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .req_sel(req_sel), .req_ack(req_ack), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_borrow(alu_borrow), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_borrow(rsp_borrow),
    .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // External ALU: raw flags always driven so masking in the DUT is exercised.
  assign alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_diff   = {1'b0, alu_a} - {1'b0, alu_b};
  assign alu_carry  = alu_sum[4];
  assign alu_borrow = alu_diff[4];
  always_comb begin
    case (alu_sel)
      2'b00:   alu_result = alu_sum[3:0];
      2'b01:   alu_result = alu_diff[3:0];
      2'b10:   alu_result = ~(alu_a & alu_b);
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic int rr_pick(int ptr, logic [N-1:0] r);
    for (int k = 1; k <= N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic int exp_res(int a, int b, int sel);
    case (sel)
      0:       return (a + b) & 15;
      1:       return (a - b) & 15;
      2:       return (~(a & b)) & 15;
      default: return (a ^ b) & 15;
    endcase
  endfunction

  // Reference model: phase 0 idle, 1 ack cycle, 2 response outstanding.
  int         m_phase = 0;
  int         m_ptr   = N - 1;
  int         m_id    = 0;
  int         w_pick;
  logic [3:0] m_a = '0, m_b = '0;
  logic [1:0] m_sel = '0;

  always_comb w_pick = rr_pick(m_ptr, req);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_ptr <= N - 1; m_id <= 0;
      m_a <= '0; m_b <= '0; m_sel <= '0;
    end else begin
      case (m_phase)
        0: if (req != '0) begin
          m_id    <= w_pick;
          m_a     <= req_a[4*w_pick +: 4];
          m_b     <= req_b[4*w_pick +: 4];
          m_sel   <= req_sel[2*w_pick +: 2];
          m_phase <= 1;
        end
        1: m_phase <= 2;
        default: if (rsp_ready) begin
          m_ptr   <= m_id;
          m_phase <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("m_ack",   req_ack,   (m_phase == 1) ? (1 << m_id) : 0);
    check("m_busy",  busy,      m_phase != 0);
    check("m_valid", rsp_valid, m_phase == 2);
    check("m_alu_a", alu_a, m_a);
    check("m_alu_b", alu_b, m_b);
    check("m_alu_sel", alu_sel, m_sel);
    if (m_phase == 2) begin
      check("m_result", rsp_result, exp_res(m_a, m_b, m_sel));
      check("m_carry",  rsp_carry,  (m_sel == 0) && (int'(m_a) + int'(m_b) > 15));
      check("m_borrow", rsp_borrow, (m_sel == 1) && (m_a < m_b));
      check("m_id",     rsp_id,     m_id);
    end
    if (req_ack != '0) ack_q.push_back(req_ack);
    if (rsp_valid && rsp_ready) id_q.push_back(int'(rsp_id));
  end

  task automatic wait_ack(output logic [N-1:0] got);
    got = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_ack != '0) begin got = req_ack; break; end
    end
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic set_op(input int i, input logic [3:0] a, b, input logic [1:0] sel);
    req_a[4*i +: 4]   = a;
    req_b[4*i +: 4]   = b;
    req_sel[2*i +: 2] = sel;
  endtask

  task automatic do_op(input int i, input logic [3:0] a, b, input logic [1:0] sel,
                       input logic [3:0] er, input logic ec, eb);
    logic [N-1:0] got;
    logic         ok;
    @(negedge clk);
    set_op(i, a, b, sel);
    req[i] = 1'b1;
    wait_ack(got);
    check("op_ack", got, 1 << i);
    req[i] = 1'b0;
    wait_valid(ok);
    check("op_valid", ok, 1);
    check("op_result", rsp_result, er);
    check("op_carry",  rsp_carry,  ec);
    check("op_borrow", rsp_borrow, eb);
    check("op_id",     rsp_id,     i);
    wait_idle();
  endtask

  task automatic run_acks(input int n, input logic [N-1:0] active);
    int cnt = 0;
    for (int c = 0; c < 200 && cnt < n; c++) begin
      @(negedge clk);
      if (req_ack != '0) cnt++;
      for (int i = 0; i < N; i++) begin
        if (req_ack[i]) req[i] = 1'b0;
        else if (active[i]) req[i] = 1'b1;
      end
    end
    check("ack_count", cnt, n);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_ack"},    req_ack,    0);
    check({tag, "_alu_a"},  alu_a,      0);
    check({tag, "_alu_b"},  alu_b,      0);
    check({tag, "_alu_sel"}, alu_sel,   0);
    check({tag, "_valid"},  rsp_valid,  0);
    check({tag, "_result"}, rsp_result, 0);
    check({tag, "_carry"},  rsp_carry,  0);
    check({tag, "_borrow"}, rsp_borrow, 0);
    check({tag, "_id"},     rsp_id,     0);
    check({tag, "_busy"},   busy,       0);
  endtask

  initial begin
    logic [N-1:0] got;
    logic         ok;
    logic [N-1:0] exp_ack[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int           exp_id[5]  = '{0, 1, 2, 3, 0};

    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single-requester ops covering every op code and flag case.
    do_op(0, 4'b0101, 4'b0011, 2'b00, 4'b1000, 1'b0, 1'b0);
    do_op(1, 4'b0010, 4'b1000, 2'b01, 4'b1010, 1'b0, 1'b1);
    do_op(1, 4'b1111, 4'b0001, 2'b00, 4'b0000, 1'b1, 1'b0);
    do_op(2, 4'b1010, 4'b1100, 2'b10, 4'b0111, 1'b0, 1'b0);
    do_op(3, 4'b0110, 4'b1010, 2'b11, 4'b1100, 1'b0, 1'b0);

    // All four requesting continuously after reset: strict rotation.
    @(negedge clk);
    rst_n = 1'b0;
    ack_q.delete();
    id_q.delete();
    set_op(0, 4'b1111, 4'b0010, 2'b01);
    set_op(1, 4'b0011, 4'b1110, 2'b00);
    set_op(2, 4'b0001, 4'b0100, 2'b10);
    set_op(3, 4'b1001, 4'b1001, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111;
    run_acks(5, 4'b1111);
    req = '0;
    wait_idle();
    check("rot_ack_n", ack_q.size(), 5);
    check("rot_id_n",  id_q.size(),  5);
    for (int k = 0; k < 5; k++) begin
      check("rot_ack", ack_q[k], exp_ack[k]);
      check("rot_id",  id_q[k],  exp_id[k]);
    end

    // Back-pressure with another request pending.
    rsp_ready = 1'b0;
    @(negedge clk);
    set_op(0, 4'b0011, 4'b0100, 2'b00);
    req[0] = 1'b1;
    wait_ack(got);
    check("bp_ack0", got, 4'b0001);
    req[0] = 1'b0;
    set_op(1, 4'b1001, 4'b0010, 2'b01);
    req[1] = 1'b1;
    wait_valid(ok);
    check("bp_valid", ok, 1);
    for (int c = 0; c < 5; c++) begin
      check("bp_result", rsp_result, 4'b0111);
      check("bp_id",     rsp_id,     0);
      check("bp_busy",   busy,       1);
      check("bp_noack",  req_ack,    0);
      check("bp_hold",   rsp_valid,  1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    wait_ack(got);
    check("bp_ack1", got, 4'b0010);
    req[1] = 1'b0;
    wait_valid(ok);
    check("bp_valid1",  ok, 1);
    check("bp_result1", rsp_result, 4'b0111);
    check("bp_borrow1", rsp_borrow, 0);
    check("bp_id1",     rsp_id,     1);
    wait_idle();

    // Reset in the middle of an outstanding response.
    rsp_ready = 1'b0;
    @(negedge clk);
    set_op(2, 4'b1111, 4'b1111, 2'b00);
    req[2] = 1'b1;
    wait_ack(got);
    check("mr_ack", got, 4'b0100);
    req[2] = 1'b0;
    wait_valid(ok);
    check("mr_valid",  ok, 1);
    check("mr_result", rsp_result, 4'b1110);
    check("mr_carry",  rsp_carry,  1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    ack_q.delete();
    id_q.delete();
    set_op(1, 4'b0110, 4'b0011, 2'b01);
    set_op(3, 4'b0010, 4'b0111, 2'b00);
    req = 4'b1010;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_acks(2, 4'b0000);
    req = '0;
    wait_idle();
    check("mr_ack_n", ack_q.size(), 2);
    check("mr_first", ack_q[0], 4'b0010);
    check("mr_second", ack_q[1], 4'b1000);
    check("mr_id_n", id_q.size(), 2);
    check("mr_id0", id_q[0], 1);
    check("mr_id1", id_q[1], 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
